tty_char_buffer: RTL and testbench

Buffers character and clear commands that the Y86 core's memory-mapped IO block writes to the TTY port, and drains them in order to the character display. It sits directly downstream of the core. It absorbs the core's TTY strobes, which may last several cycles, and drives a valid/ready handshake toward the display. Back-pressure is returned to the core as a TTY-ready level.

---
 rtl/tty_pkg.sv | 15 +
 rtl/tty_sync_fifo.sv | 69 ++++++
 rtl/tty_char_buffer.sv | 104 ++++++++++
 tb/tb_tty_char_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tty_pkg.sv
// Shared definitions for the TTY character buffer: default geometry and the
// FIFO entry layout {is_clear, ch}.
// Imported by tty_sync_fifo and tty_char_buffer.
package tty_pkg;

    localparam int TTY_DATA_W = 7;
    localparam int TTY_DEPTH  = 16;

    // A clear command is stored with ch = 0 so the display never sees stale data.
    typedef struct packed {
        logic                  is_clear;
        logic [TTY_DATA_W-1:0] ch;
    } tty_entry_t;

endpackage

// File: rtl/tty_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy and full/empty flags.
// Ports: clk/reset (sync, active-high), wr_en/wr_dat, rd_en/rd_dat (head, combinational),
//        full, empty, fill (0..DEPTH). Writes while full and reads while empty are ignored.
module tty_sync_fifo
    import tty_pkg::*;
#(
    parameter int  DEPTH = TTY_DEPTH,
    parameter type T     = tty_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  T                             wr_dat,
    input  logic                         rd_en,
    output T                             rd_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);

    T                  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              do_wr, do_rd;

    assign full   = (fill_q == FILL_W'(DEPTH));
    assign empty  = (fill_q == '0);
    assign fill   = fill_q;
    assign rd_dat = mem_q[rd_ptr_q];

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: the pointers and fill define which slots are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/tty_char_buffer.sv
// Buffers the core's TTY character/clear strobes and drains them in order to the display.
// Ports: cpu_data/cpu_en/cpu_clear (level strobes) -> cpu_ready; disp_* valid/ready toward
//        the display; fill = FIFO occupancy (output register excluded); overflow is sticky.
module tty_char_buffer
    import tty_pkg::*;
#(
    parameter int DEPTH  = TTY_DEPTH,
    parameter int DATA_W = TTY_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           cpu_data,
    input  logic                        cpu_en,
    input  logic                        cpu_clear,
    output logic                        cpu_ready,
    output logic [DATA_W-1:0]           disp_data,
    output logic                        disp_clear,
    output logic                        disp_valid,
    input  logic                        disp_ready,
    output logic [$clog2(DEPTH+1)-1:0]  fill,
    output logic                        overflow
);

    typedef struct packed {
        logic              is_clear;
        logic [DATA_W-1:0] ch;
    } entry_t;

    logic   en_q, clr_q;
    logic   out_vld_q, out_vld_d;
    entry_t out_entry_q, out_entry_d;
    logic   overflow_q, overflow_d;

    logic   push_char, push_clr, push_any;
    logic   fifo_full, fifo_empty;
    entry_t wr_entry, fifo_head;
    logic   load, pop;

    // One entry per rising strobe, no matter how long the core holds it.
    assign push_char = cpu_en & ~en_q;
    assign push_clr  = cpu_clear & ~clr_q;
    assign push_any  = push_char | push_clr;

    // A coincident clear wins and the character is silently discarded.
    assign wr_entry.is_clear = push_clr;
    assign wr_entry.ch       = push_clr ? '0 : cpu_data;

    // Head moves into the output register whenever that register is free or being
    // emptied this cycle, which gives one transfer per cycle when draining.
    assign pop  = out_vld_q & disp_ready;
    assign load = ~fifo_empty & (~out_vld_q | disp_ready);

    tty_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_any),
        .wr_dat (wr_entry),
        .rd_en  (load),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .fill   (fill)
    );

    always_comb begin
        out_vld_d   = out_vld_q;
        out_entry_d = out_entry_q;
        if (load) begin
            out_vld_d   = 1'b1;
            out_entry_d = fifo_head;
        end else if (pop) begin
            out_vld_d   = 1'b0;
        end
    end

    // A push that meets a full FIFO is dropped by the FIFO and flagged here.
    assign overflow_d = overflow_q | (push_any & fifo_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            out_entry_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            en_q        <= cpu_en;
            clr_q       <= cpu_clear;
            out_vld_q   <= out_vld_d;
            out_entry_q <= out_entry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cpu_ready  = ~fifo_full;
    assign disp_valid = out_vld_q;
    assign disp_data  = out_entry_q.ch;
    assign disp_clear = out_vld_q & out_entry_q.is_clear;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tty_char_buffer.sv
// Directed testbench for tty_char_buffer: strobe edge detection, ordering, full/overflow,
// clear arbitration, mid-drain reset and a toggling display handshake.
// Inputs are driven 1 ns after the rising edge; transfers are recorded on the falling edge.
module tb_tty_char_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] cpu_data;
    logic       cpu_en;
    logic       cpu_clear;
    logic       cpu_ready;
    logic [6:0] disp_data;
    logic       disp_clear;
    logic       disp_valid;
    logic       disp_ready;
    logic [4:0] fill;
    logic       overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    logic toggle_en = 1'b0;

    // Received display transfers, encoded {clear, data}.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    logic       stall_pend = 1'b0;
    logic [7:0] stall_dat  = '0;

    always #5 clk = ~clk;

    tty_char_buffer #(.DEPTH(16), .DATA_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_data   (cpu_data),
        .cpu_en     (cpu_en),
        .cpu_clear  (cpu_clear),
        .cpu_ready  (cpu_ready),
        .disp_data  (disp_data),
        .disp_clear (disp_clear),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .fill       (fill),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfer monitor and stall-stability check.
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_vld", {31'd0, disp_valid}, 32'd1);
                check("stall_dat", {24'd0, disp_clear, disp_data}, {24'd0, stall_dat});
            end
            if (disp_valid && disp_ready) rx_q.push_back({disp_clear, disp_data});
            stall_pend = disp_valid & ~disp_ready;
            stall_dat  = {disp_clear, disp_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) disp_ready = ~disp_ready;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [6:0] d);
        cpu_data = d;
        cpu_en   = 1'b1;
        tick();
        cpu_en   = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((fill != 0 || disp_valid) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, {31'd0, (n >= 300)}, 32'd0);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_entry%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cpu_data   = '0;
        cpu_en     = 1'b0;
        cpu_clear  = 1'b0;
        disp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid",    {31'd0, disp_valid}, 32'd0);
        check("rst_clear",    {31'd0, disp_clear}, 32'd0);
        check("rst_data",     {25'd0, disp_data},  32'd0);
        check("rst_fill",     {27'd0, fill},       32'd0);
        check("rst_overflow", {31'd0, overflow},   32'd0);
        check("rst_ready",    {31'd0, cpu_ready},  32'd1);

        // Long strobe: one transfer, valid two edges after the strobe is first sampled.
        disp_ready = 1'b1;
        cpu_data   = 7'h41;
        cpu_en     = 1'b1;
        tick();
        check("t1_fill_after_push", {27'd0, fill}, 32'd1);
        check("t1_valid_early",     {31'd0, disp_valid}, 32'd0);
        tick();
        check("t1_valid_rise", {31'd0, disp_valid}, 32'd1);
        check("t1_data",       {25'd0, disp_data},  32'h41);
        check("t1_fill_zero",  {27'd0, fill},       32'd0);
        tick();
        tick();
        tick();
        cpu_en = 1'b0;
        tick();
        exp_q.push_back(8'h41);
        compare_rx("t1");
        check("t1_fill_end", {27'd0, fill}, 32'd0);

        // Ordering of characters and a clear.
        strobe(7'h48);
        strobe(7'h69);
        cpu_data  = 7'h33;
        cpu_clear = 1'b1;
        tick();
        cpu_clear = 1'b0;
        tick();
        strobe(7'h21);
        wait_drain("t2");
        exp_q = '{8'h48, 8'h69, 8'h80, 8'h21};
        compare_rx("t2");

        // Fill to capacity with the display stalled, then overflow.
        disp_ready = 1'b0;
        for (int i = 0; i < 17; i++) strobe(7'(8'h30 + i));
        check("t3_fill_full",   {27'd0, fill},      32'd16);
        check("t3_ready_low",   {31'd0, cpu_ready}, 32'd0);
        check("t3_no_overflow", {31'd0, overflow},  32'd0);
        check("t3_head",        {25'd0, disp_data}, 32'h30);
        strobe(7'h41);
        check("t3_overflow",    {31'd0, overflow},  32'd1);
        check("t3_fill_still",  {27'd0, fill},      32'd16);
        disp_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        check("t3_b2b_count",  rx_q.size(),         32'd17);
        check("t3_b2b_idle",   {31'd0, disp_valid}, 32'd0);
        check("t3_ready_back", {31'd0, cpu_ready},  32'd1);
        check("t3_ovf_sticky", {31'd0, overflow},   32'd1);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h30 + i));
        compare_rx("t3");

        // Simultaneous clear and character: only the clear survives.
        do_reset();
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        cpu_data  = 7'h5A;
        cpu_en    = 1'b1;
        cpu_clear = 1'b1;
        tick();
        cpu_en    = 1'b0;
        cpu_clear = 1'b0;
        tick();
        wait_drain("t4");
        exp_q.push_back(8'h80);
        compare_rx("t4");
        check("t4_overflow", {31'd0, overflow}, 32'd0);

        // Reset with six entries queued behind a stalled output register.
        disp_ready = 1'b0;
        for (int i = 0; i < 7; i++) strobe(7'(8'h50 + i));
        check("t5_fill_six", {27'd0, fill}, 32'd6);
        do_reset();
        check("t5_valid",    {31'd0, disp_valid}, 32'd0);
        check("t5_fill",     {27'd0, fill},       32'd0);
        check("t5_ready",    {31'd0, cpu_ready},  32'd1);
        check("t5_overflow", {31'd0, overflow},   32'd0);
        rx_q.delete();
        disp_ready = 1'b1;
        strobe(7'h31);
        wait_drain("t5");
        exp_q.push_back(8'h31);
        compare_rx("t5");

        // Display ready toggling every cycle.
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) strobe(7'(8'h61 + i));
        wait_drain("t6");
        toggle_en  = 1'b0;
        disp_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h61 + i));
        compare_rx("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
